// File: rtl/fifo_read_scheduler.sv
// Read-side scheduler for the async FIFO: round-robin burst grants between two requesters,
// FIFO read issue with one-cycle latency absorbed by a 2-entry skid buffer on a valid/ready stream.
module fifo_read_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  read_clk,
    input  logic                  write_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [1:0]            req,
    output logic [1:0]            gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_id,
    output logic                  out_last,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(BURST_LEN - 1);

    state_t                state;
    state_t                state_next;
    logic                  rr_ptr;
    logic                  win_id;
    logic                  grant_id;
    logic [CNT_WIDTH-1:0]  issued;
    logic [CNT_WIDTH-1:0]  captured;
    logic                  in_flight;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_last [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic [1:0]            committed;
    logic                  pop;
    logic                  rd_en;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_data[rd_ptr];
    assign out_last  = out_valid && buf_last[rd_ptr];
    assign out_id    = win_id;
    assign grant_id  = (req == 2'b11) ? rr_ptr : req[1];

    // Words that will still need a buffer slot after this cycle's accept; a new read
    // is allowed while this stays below two, which keeps 1 word/cycle when out_ready=1.
    assign committed = occ - {1'b0, pop} + {1'b0, in_flight};

    always_ff @(posedge read_clk or posedge write_rst) begin
        if (write_rst) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 2'b00) state_next = READ;
            READ:    if (rd_en && (issued == LAST_IDX)) state_next = DRAIN;
            DRAIN:   if (!in_flight && (occ == 2'd0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state == READ) && !fifo_empty && (issued < BURST_CNT) && (committed < 2'd2);
        fifo_rd_en = rd_en;
        busy       = (state != IDLE);
    end

    // Grant, round-robin pointer and per-burst counters; the pointer moves to the
    // non-winner only once the burst's last word has left the buffer.
    always_ff @(posedge read_clk or posedge write_rst) begin
        if (write_rst) begin
            gnt      <= 2'b00;
            win_id   <= 1'b0;
            rr_ptr   <= 1'b0;
            issued   <= '0;
            captured <= '0;
        end else begin
            if (state == IDLE && req != 2'b00) begin
                win_id   <= grant_id;
                gnt      <= grant_id ? 2'b10 : 2'b01;
                issued   <= '0;
                captured <= '0;
            end else begin
                if (rd_en)     issued   <= issued + 1'b1;
                if (in_flight) captured <= captured + 1'b1;
            end
            if (state == DRAIN && state_next == IDLE) begin
                gnt    <= 2'b00;
                rr_ptr <= ~win_id;
            end
        end
    end

    always_ff @(posedge read_clk or posedge write_rst) begin
        if (write_rst) begin
            in_flight <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            in_flight <= rd_en;
            if (in_flight) begin
                buf_data[wr_ptr] <= fifo_rd_data;
                buf_last[wr_ptr] <= (captured == LAST_IDX);
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Self-checking bench: queue-based FIFO model plus a stream scoreboard that predicts
// grant order, word order, out_id and out_last from the scheduling rules.
module tb_fifo_read_scheduler;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 3;

    logic          read_clk = 1'b0;
    logic          write_rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_id;
    logic          out_last;
    logic          busy;

    fifo_read_scheduler #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .read_clk(read_clk), .write_rst(write_rst), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .req(req), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .busy(busy)
    );

    always #5 read_clk = ~read_clk;

    int tests = 0;
    int failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q [$];
    logic          win_log [$];
    logic          rd_en_s = 1'b0;

    // FIFO model: one word popped per sampled read enable, data valid the next cycle.
    always @(posedge read_clk) begin
        if (rd_en_s && !write_rst && fifo_q.size() > 0) begin
            exp_q.push_back(fifo_q[0]);
            fifo_rd_data <= fifo_q.pop_front();
            fifo_empty   <= (fifo_q.size() == 0);
        end
    end

    logic        rr_model = 1'b0;
    logic        cur_win = 1'b0;
    logic        exp_win;
    logic [1:0]  prev_gnt = 2'b00;
    logic [1:0]  prev_req = 2'b00;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [9:0]  prev_bundle = '0;
    logic [31:0] exp_w;
    int          burst_cnt = 0;
    int          accepted = 0;
    int          grants = 0;

    // Scoreboard: grants follow round-robin on the previous cycle's req, the stream is
    // the popped words in order, each burst holds BL words with out_last on the BL-th.
    always @(negedge read_clk) begin
        rd_en_s = fifo_rd_en;
        if (write_rst) begin
            exp_q.delete();
            rr_model   = 1'b0;
            prev_gnt   = 2'b00;
            prev_valid = 1'b0;
            burst_cnt  = 0;
        end else begin
            if (fifo_empty) checkOutput("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
            if (prev_gnt == 2'b00 && gnt != 2'b00) begin
                exp_win = (prev_req == 2'b11) ? rr_model : prev_req[1];
                checkOutput("grant", {30'd0, gnt}, exp_win ? 32'd2 : 32'd1);
                cur_win   = exp_win;
                burst_cnt = 0;
                win_log.push_back(exp_win);
                grants++;
            end
            if (prev_gnt != 2'b00 && gnt == 2'b00) begin
                checkOutput("burst_len", burst_cnt, BL);
                rr_model = !cur_win;
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("hold_bundle", {22'd0, out_id, out_last, out_data}, {22'd0, prev_bundle});
            end
            if (out_valid && out_ready) begin
                exp_w = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD;
                checkOutput("data", {24'd0, out_data}, exp_w);
                checkOutput("id", {31'd0, out_id}, {31'd0, cur_win});
                checkOutput("last", {31'd0, out_last}, (burst_cnt == BL - 1) ? 32'd1 : 32'd0);
                burst_cnt++;
                accepted++;
            end
            prev_gnt    = gnt;
            prev_valid  = out_valid;
            prev_ready  = out_ready;
            prev_bundle = {out_id, out_last, out_data};
        end
        prev_req = req;
    end

    task automatic applyStimulus(input logic [1:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        @(posedge read_clk);
        #2;
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clearFifo();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic doReset();
        @(posedge read_clk);
        #3;
        write_rst = 1'b1;
        #1;
        checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        checkOutput("rst_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, out_data}, 32'd0);
        checkOutput("rst_id_last_busy", {29'd0, out_id, out_last, busy}, 32'd0);
        @(posedge read_clk);
        #2;
        write_rst = 1'b0;
        applyStimulus(2'b00, 1'b1);
    endtask

    task automatic waitAccepted(input int target, input int budget, input string tag);
        int n = 0;
        while (accepted < target && n < budget) begin
            applyStimulus(req, out_ready);
            n++;
        end
        if (accepted < target) checkOutput(tag, accepted, target);
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while ((busy || gnt != 2'b00) && n < budget) begin
            applyStimulus(req, out_ready);
            n++;
        end
        checkOutput(tag, {30'd0, busy, gnt != 2'b00}, 32'd0);
    endtask

    int base;
    int lat;
    int gbase;
    logic [DW-1:0] head;

    initial begin
        write_rst    = 1'b1;
        req          = 2'b00;
        out_ready    = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        repeat (2) @(posedge read_clk);
        #2;
        write_rst = 1'b0;

        // Single requester burst with exact latency and back-to-back delivery.
        doReset();
        clearFifo();
        for (int i = 17; i <= 24; i++) pushWord(DW'(i));
        base = accepted;
        applyStimulus(2'b01, 1'b1);
        checkOutput("t1_gnt", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        lat = 0;
        while (!out_valid && lat < 10) begin
            applyStimulus(2'b00, 1'b1);
            lat++;
        end
        checkOutput("t1_latency", lat, 2);
        for (int i = 0; i < BL; i++) begin
            checkOutput("t1_stream", {22'd0, out_valid, out_last, out_data},
                        {22'd0, 1'b1, (i == BL - 1), DW'(17 + i)});
            applyStimulus(2'b00, 1'b1);
        end
        waitIdle(10, "t1_idle");

        // Both requesters: alternating grants over four bursts.
        doReset();
        clearFifo();
        win_log.delete();
        for (int i = 17; i <= 32; i++) pushWord(DW'(i));
        base = accepted;
        applyStimulus(2'b11, 1'b1);
        waitAccepted(base + 16, 200, "t2_timeout");
        req = 2'b00;
        waitIdle(20, "t2_idle");
        checkOutput("t2_bursts", win_log.size(), 4);
        for (int i = 0; i < win_log.size() && i < 4; i++)
            checkOutput("t2_order", {31'd0, win_log[i]}, i % 2);

        // Backpressure: reads stop while the stream is stalled.
        doReset();
        clearFifo();
        for (int i = 17; i <= 24; i++) pushWord(DW'(i));
        base = accepted;
        applyStimulus(2'b01, 1'b1);
        req = 2'b00;
        waitAccepted(base + 1, 20, "t3_timeout");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 1'b0);
            if (i >= 1) checkOutput("t3_rd_stall", {31'd0, fifo_rd_en}, 32'd0);
        end
        out_ready = 1'b1;
        waitIdle(30, "t3_idle");
        checkOutput("t3_count", accepted - base, BL);

        // FIFO runs dry mid-burst: stall, then resume.
        doReset();
        clearFifo();
        pushWord(8'd17);
        pushWord(8'd18);
        base = accepted;
        applyStimulus(2'b01, 1'b1);
        req = 2'b00;
        repeat (10) applyStimulus(2'b00, 1'b1);
        checkOutput("t4_partial", accepted - base, 2);
        checkOutput("t4_stall", {29'd0, busy, fifo_rd_en, gnt == 2'b01}, 32'b101);
        pushWord(8'd19);
        pushWord(8'd20);
        waitIdle(30, "t4_idle");
        checkOutput("t4_count", accepted - base, BL);

        // Reset mid-burst, then fresh burst to requester 1 from the FIFO head.
        doReset();
        clearFifo();
        for (int i = 17; i <= 28; i++) pushWord(DW'(i));
        base = accepted;
        applyStimulus(2'b01, 1'b1);
        req = 2'b00;
        waitAccepted(base + 2, 20, "t5_timeout");
        doReset();
        head = fifo_q[0];
        base = accepted;
        applyStimulus(2'b10, 1'b1);
        checkOutput("t5_gnt", {30'd0, gnt}, 32'd2);
        req = 2'b00;
        lat = 0;
        while (!out_valid && lat < 10) begin
            applyStimulus(2'b00, 1'b1);
            lat++;
        end
        checkOutput("t5_head", {24'd0, out_data}, {24'd0, head});
        waitIdle(20, "t5_idle");
        checkOutput("t5_count", accepted - base, BL);

        // One-cycle request pulse still yields exactly one full burst.
        doReset();
        clearFifo();
        for (int i = 40; i < 48; i++) pushWord(DW'(i));
        base  = accepted;
        gbase = grants;
        applyStimulus(2'b01, 1'b1);
        req = 2'b00;
        waitIdle(30, "t6_idle");
        repeat (20) applyStimulus(2'b00, 1'b1);
        checkOutput("t6_grants", grants - gbase, 1);
        checkOutput("t6_count", accepted - base, BL);

        // Randomized traffic against the scoreboard.
        doReset();
        clearFifo();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) pushWord(DW'($urandom));
            if ($urandom_range(0, 7) == 0) req = 2'($urandom);
            applyStimulus(req, 1'($urandom_range(0, 3) != 0));
        end
        req = 2'b00;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (busy || gnt != 2'b00); c++) begin
            if (fifo_empty) pushWord(DW'($urandom));
            applyStimulus(2'b00, 1'b1);
        end
        waitIdle(10, "rand_idle");
        checkOutput("rand_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
